vga_pixel_pipeline: RTL and testbench

//  Downstream stage of the VGA timing controller: takes counterX/counterY, H_SYNC, V_SYNC and SYNC_BLANK.

---
 rtl/vga_pixel_pipeline.sv | 177 +++++++++++++++++
 tb/tb_vga_pixel_pipeline.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipeline.sv
// Pixel path behind the VGA timing controller: frame-buffer read addressing, RGB332 expansion,
// sync/blank alignment and a double-buffer swap that only takes effect during vertical blank.
module vga_pixel_pipeline #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned RD_LAT      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [12:0]       counterX,
    input  logic [12:0]       counterY,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic              blank_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              fb_sel,
    output logic              frame_start,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              H_SYNC_out,
    output logic              V_SYNC_out,
    output logic              BLANK_out
);
    localparam int unsigned LAT       = RD_LAT + 2;
    localparam int unsigned BUF_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned BUF_H     = V_ACTIVE >> SCALE_SHIFT;
    localparam int unsigned BUF_WORDS = BUF_W * BUF_H;

    localparam logic [12:0]       H_LIM      = 13'(H_ACTIVE);
    localparam logic [12:0]       V_LIM      = 13'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] BUF_BASE   = ADDR_W'(BUF_WORDS);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(BUF_W);

    typedef enum logic [1:0] {StIdle, StPending, StAcked} swap_state_e;

    swap_state_e state_q, state_d;
    logic        toggle;
    logic        fb_sel_q;
    logic        swap_ack_q;
    logic        frame_start_q;

    logic              pix_active;
    logic              swap_point;
    logic [12:0]       x_scaled;
    logic [12:0]       y_scaled;
    logic [ADDR_W-1:0] addr_d;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic [RD_LAT-1:0] act_pipe_q;
    logic [LAT-1:0]    hs_pipe_q;
    logic [LAT-1:0]    vs_pipe_q;
    logic [LAT-1:0]    bl_pipe_q;
    logic [7:0]        r_q, g_q, b_q;

    // Out-of-range coordinates never fetch, even if blank_in claims active video.
    assign pix_active = blank_in && (counterX < H_LIM) && (counterY < V_LIM);
    assign swap_point = (counterX == '0) && (counterY == V_LIM);

    assign x_scaled = counterX >> SCALE_SHIFT;
    assign y_scaled = counterY >> SCALE_SHIFT;
    assign addr_d   = ADDR_W'(y_scaled) * LINE_WORDS + ADDR_W'(x_scaled)
                    + (fb_sel_q ? BUF_BASE : '0);

    // Stage A: read request; the address holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_en_q <= pix_active;
            if (pix_active) begin
                rd_addr_q <= addr_d;
            end
        end
    end

    // Stage B/C: track which read-data beats are real, then expand RGB332 to 8-bit channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_pipe_q <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            act_pipe_q[0] <= rd_en_q;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                act_pipe_q[i] <= act_pipe_q[i-1];
            end
            if (act_pipe_q[RD_LAT-1]) begin
                r_q <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
                g_q <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
                b_q <= {4{rd_data[1:0]}};
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
            bl_pipe_q <= '0;
        end else begin
            hs_pipe_q[0] <= h_sync_in;
            vs_pipe_q[0] <= v_sync_in;
            bl_pipe_q[0] <= blank_in;
            for (int i = 1; i < int'(LAT); i++) begin
                hs_pipe_q[i] <= hs_pipe_q[i-1];
                vs_pipe_q[i] <= vs_pipe_q[i-1];
                bl_pipe_q[i] <= bl_pipe_q[i-1];
            end
        end
    end

    // Swap only at the first blank pixel after the last visible line, once per request.
    always_comb begin
        state_d = state_q;
        toggle  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (swap_req) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (swap_point) begin
                    state_d = StAcked;
                    toggle  = 1'b1;
                end
            end
            StAcked: begin
                if (!swap_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            fb_sel_q      <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fb_sel_q      <= fb_sel_q ^ toggle;
            swap_ack_q    <= toggle;
            frame_start_q <= (counterX == '0) && (counterY == '0);
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign swap_ack    = swap_ack_q;
    assign fb_sel      = fb_sel_q;
    assign frame_start = frame_start_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign H_SYNC_out  = hs_pipe_q[LAT-1];
    assign V_SYNC_out  = vs_pipe_q[LAT-1];
    assign BLANK_out   = bl_pipe_q[LAT-1];

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Randomized bench for vga_pixel_pipeline: a frame-buffer emulator feeds rd_data, and an
// arithmetic reference model predicts every output cycle by cycle.
module tb_vga_pixel_pipeline;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int RD_LAT    = 2;
    localparam int LAT       = RD_LAT + 2;
    localparam int BUF_WORDS = (H_ACTIVE / 4) * (V_ACTIVE / 4);
    localparam int NCYC      = 12000;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] counterX, counterY;
    logic        h_sync_in, v_sync_in, blank_in, swap_req;
    logic [7:0]  rd_data;
    logic        rd_en, swap_ack, fb_sel, frame_start, H_SYNC_out, V_SYNC_out, BLANK_out;
    logic [15:0] rd_addr;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    vga_pixel_pipeline #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .SCALE_SHIFT(2), .ADDR_W(16), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .counterX(counterX), .counterY(counterY),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .blank_in(blank_in),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .swap_req(swap_req), .swap_ack(swap_ack), .fb_sel(fb_sel), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .H_SYNC_out(H_SYNC_out), .V_SYNC_out(V_SYNC_out), .BLANK_out(BLANK_out)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit en; int addr; bit ack; bit fb; bit fs; } exp_a_t;
    typedef struct { bit v; int r; int g; int b; bit hs; bit vs; bit bl; } exp_l_t;

    exp_a_t     exp_a    [NCYC+16];
    exp_l_t     exp_l    [NCYC+16];
    bit         obs_en   [NCYC+16];
    int         obs_addr [NCYC+16];
    logic [7:0] mem      [2*BUF_WORDS];

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int m_addr;
    bit m_fb, m_wait, m_done;
    bit hs_st, vs_st, req_st;

    function automatic int scale3(input int v);
        return (v * 255 + 3) / 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic compare();
        if (exp_a[cyc].v) begin
            chk("rd_en", rd_en, exp_a[cyc].en);
            chk("rd_addr", rd_addr, exp_a[cyc].addr);
            chk("swap_ack", swap_ack, exp_a[cyc].ack);
            chk("fb_sel", fb_sel, exp_a[cyc].fb);
            chk("frame_start", frame_start, exp_a[cyc].fs);
        end
        if (exp_l[cyc].v) begin
            chk("VGA_R", VGA_R, exp_l[cyc].r);
            chk("VGA_G", VGA_G, exp_l[cyc].g);
            chk("VGA_B", VGA_B, exp_l[cyc].b);
            chk("H_SYNC_out", H_SYNC_out, exp_l[cyc].hs);
            chk("V_SYNC_out", V_SYNC_out, exp_l[cyc].vs);
            chk("BLANK_out", BLANK_out, exp_l[cyc].bl);
        end
    endtask

    // Frame-buffer emulator: answers a read RD_LAT cycles after the strobe, garbage otherwise.
    task automatic mem_drive();
        obs_en[cyc]   = (rd_en === 1'b1);
        obs_addr[cyc] = int'(rd_addr);
        if (cyc >= RD_LAT && obs_en[cyc-RD_LAT] && obs_addr[cyc-RD_LAT] < 2 * BUF_WORDS)
            rd_data = mem[obs_addr[cyc-RD_LAT]];
        else
            rd_data = 8'($urandom);
    endtask

    task automatic stim(input int x, input int y, input bit hs, input bit vs, input bit bl,
                        input bit req);
        bit act, sp, sw;
        int d;
        counterX  = 13'(x);
        counterY  = 13'(y);
        h_sync_in = hs;
        v_sync_in = vs;
        blank_in  = bl;
        swap_req  = req;
        act = bl && x < H_ACTIVE && y < V_ACTIVE;
        sp  = (x == 0 && y == V_ACTIVE);
        sw  = m_wait && sp;
        if (act) m_addr = (m_fb ? BUF_WORDS : 0) + (y / 4) * (H_ACTIVE / 4) + x / 4;
        exp_a[cyc+1] = '{1'b1, act, m_addr, sw, m_fb ^ sw, (x == 0 && y == 0)};
        if (sw) begin
            m_fb   = ~m_fb;
            m_wait = 1'b0;
            m_done = 1'b1;
        end else if (m_done) begin
            if (!req) m_done = 1'b0;
        end else if (req && !m_wait) begin
            m_wait = 1'b1;
        end
        d = act ? int'(mem[m_addr]) : 0;
        exp_l[cyc+LAT] = '{1'b1, scale3(d >> 5), scale3((d >> 2) & 7), (d & 3) * 85, hs, vs, bl};
    endtask

    task automatic step(input int x, input int y, input bit hs, input bit vs, input bit bl,
                        input bit req);
        tick();
        compare();
        mem_drive();
        stim(x, y, hs, vs, bl, req);
    endtask

    task automatic rand_step();
        int x, y, k;
        bit bl;
        k = $urandom_range(0, 99);
        if (k < 55) begin
            x = $urandom_range(0, 639); y = $urandom_range(0, 479); bl = 1'b1;
        end else if (k < 75) begin
            x = $urandom_range(0, 799); y = $urandom_range(0, 524); bl = 1'b0;
        end else if (k < 83) begin
            x = $urandom_range(640, 799); y = $urandom_range(0, 524); bl = 1'b1;
        end else if (k < 88) begin
            x = $urandom_range(0, 639); y = $urandom_range(480, 524); bl = 1'b1;
        end else if (k < 95) begin
            x = 0; y = V_ACTIVE; bl = 1'($urandom_range(0, 1));
        end else begin
            x = 0; y = 0; bl = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) hs_st = ~hs_st;
        if ($urandom_range(0, 15) == 0) vs_st = ~vs_st;
        if ($urandom_range(0, 39) == 0) req_st = ~req_st;
        step(x, y, hs_st, vs_st, bl, req_st);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_swap_ack"}, swap_ack, 0);
        chk({tag, "_fb_sel"}, fb_sel, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        chk({tag, "_blank"}, BLANK_out, 0);
        chk({tag, "_hsync"}, H_SYNC_out, 1);
        chk({tag, "_vsync"}, V_SYNC_out, 1);
    endtask

    // Reset asserted between edges, held across three edges, released with an active pixel queued.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        reset_check("rst_async");
        repeat (3) begin
            tick();
            reset_check("rst_hold");
            mem_drive();
            counterX  = 13'($urandom_range(0, 639));
            counterY  = 13'($urandom_range(0, 479));
            blank_in  = 1'b1;
            h_sync_in = 1'($urandom);
            v_sync_in = 1'($urandom);
            swap_req  = 1'($urandom);
        end
        rst    = 1'b0;
        m_addr = 0;
        m_fb   = 1'b0;
        m_wait = 1'b0;
        m_done = 1'b0;
        hs_st  = 1'b1;
        vs_st  = 1'b1;
        req_st = 1'b0;
        for (int i = 1; i < LAT; i++) exp_l[cyc+i] = '{1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b0};
        stim($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2 * BUF_WORDS; i++) mem[i] = 8'($urandom);
        mem[161] = 8'hE0;
        mem[162] = 8'hFF;
        rst = 1'b0; counterX = '0; counterY = '0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        blank_in = 1'b0; swap_req = 1'b0; rd_data = '0;
        #2;
        do_reset();

        // Addressing, colour expansion, range guard and sync delay.
        step(4, 4, 1, 1, 1, 0);
        step(640, 4, 0, 1, 0, 0);
        chk("addr_4_4", rd_addr, 161); chk("rd_en_active", rd_en, 1);
        step(8, 4, 0, 0, 1, 0);
        chk("rd_en_x640", rd_en, 0); chk("addr_hold", rd_addr, 161);
        step(640, 10, 1, 1, 1, 0);
        chk("addr_8_4", rd_addr, 162);
        step(2, 2, 1, 1, 0, 0);
        chk("rd_en_out_of_range", rd_en, 0);
        chk("rgb_e0", {VGA_R, VGA_G, VGA_B}, 24'hFF0000);
        chk("hsync_pre", H_SYNC_out, 1); chk("blank_lit0", BLANK_out, 1);
        step(2, 2, 1, 1, 0, 0);
        chk("rgb_x640", {VGA_R, VGA_G, VGA_B}, 0);
        chk("hsync_fall", H_SYNC_out, 0); chk("vsync_pre", V_SYNC_out, 1);
        chk("blank_lit1", BLANK_out, 0);
        step(2, 2, 1, 1, 0, 0);
        chk("rgb_ff", {VGA_R, VGA_G, VGA_B}, 24'hFFFFFF);
        chk("hsync_low2", H_SYNC_out, 0); chk("vsync_fall", V_SYNC_out, 0);
        step(2, 2, 1, 1, 0, 0);
        chk("rgb_oor_blank1", {VGA_R, VGA_G, VGA_B}, 0);
        chk("hsync_rise", H_SYNC_out, 1); chk("vsync_rise", V_SYNC_out, 1);

        // Buffer swap handshake.
        step(5, 100, 1, 1, 1, 1);
        step(6, 100, 1, 1, 1, 1);
        step(0, V_ACTIVE, 1, 1, 0, 1);
        step(0, 0, 1, 1, 1, 1);
        chk("swap_ack_first", swap_ack, 1); chk("fb_sel_first", fb_sel, 1);
        step(1, 0, 1, 1, 1, 1);
        chk("swap_ack_pulse", swap_ack, 0); chk("addr_back_buf", rd_addr, 19200);
        chk("frame_start_lit", frame_start, 1);
        repeat (2) begin
            step(0, V_ACTIVE, 1, 1, 0, 1);
            step(9, 9, 1, 1, 1, 1);
            chk("ack_held_req", swap_ack, 0); chk("fb_held_req", fb_sel, 1);
        end
        step(9, 9, 1, 1, 1, 0);
        step(0, V_ACTIVE, 1, 1, 0, 1);
        step(0, V_ACTIVE, 1, 1, 0, 1);
        chk("ack_req_at_point", swap_ack, 0); chk("fb_req_at_point", fb_sel, 1);
        step(0, 0, 1, 1, 1, 1);
        chk("swap_ack_second", swap_ack, 1); chk("fb_sel_second", fb_sel, 0);
        step(1, 1, 1, 1, 1, 0);
        chk("addr_front_buf", rd_addr, 0);

        hs_st = 1'b1; vs_st = 1'b1; req_st = 1'b0;
        repeat (4500) rand_step();
        step(320, 200, hs_st, vs_st, 1, req_st);
        #2;
        do_reset();
        repeat (4500) rand_step();
        repeat (LAT) step(700, 500, hs_st, vs_st, 0, req_st);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
